// File: rtl/tlc_preempt_ctrl.sv
// Emergency-vehicle preemption controller between the normal traffic-light FSM and the lamp drivers.
// Passes the FSM lamps through in IDLE and otherwise drives yellow / all-red / grant-green / all-red.
module tlc_preempt_ctrl #(
    parameter int n        = 13,
    parameter int YELLOW_T = 1000,
    parameter int CLEAR_T  = 500,
    parameter int HOLD_T   = 2000
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic pre_a,
    input  logic pre_b,
    input  logic fsm_Ga,
    input  logic fsm_Ya,
    input  logic fsm_Ra,
    input  logic fsm_Gb,
    input  logic fsm_Yb,
    input  logic fsm_Rb,
    output logic Ga,
    output logic Ya,
    output logic Ra,
    output logic Gb,
    output logic Yb,
    output logic Rb,
    output logic preempt_active,
    output logic fsm_restart
);
    typedef enum logic [2:0] {IDLE, EXIT_Y, CLR_IN, GRANT, CLR_OUT} state_t;
    typedef enum logic [1:0] {ACT_NONE, ACT_A, ACT_B} act_t;

    localparam logic TGT_A = 1'b0;
    localparam logic TGT_B = 1'b1;

    localparam logic [n-1:0] Y_LAST = n'(YELLOW_T - 1);
    localparam logic [n-1:0] C_LAST = n'(CLEAR_T - 1);
    localparam logic [n-1:0] H_LAST = n'(HOLD_T - 1);

    // Lamp vectors are packed {Ga,Ya,Ra,Gb,Yb,Rb}
    localparam logic [5:0] ALL_RED = 6'b001_001;
    localparam logic [5:0] YEL_A   = 6'b010_001;
    localparam logic [5:0] YEL_B   = 6'b001_010;
    localparam logic [5:0] GRN_A   = 6'b100_001;
    localparam logic [5:0] GRN_B   = 6'b001_100;

    state_t       state, state_nxt;
    act_t         act, act_nxt;
    logic         tgt, tgt_nxt;
    logic [n-1:0] cnt, cnt_nxt;
    logic [5:0]   lamps, lamps_nxt;
    logic         restart_nxt;

    logic [5:0]   fsm_lamps;
    logic         fsm_a_on, fsm_b_on, pre_tgt;

    assign fsm_lamps = {fsm_Ga, fsm_Ya, fsm_Ra, fsm_Gb, fsm_Yb, fsm_Rb};
    assign fsm_a_on  = fsm_Ga | fsm_Ya;
    assign fsm_b_on  = fsm_Gb | fsm_Yb;
    assign pre_tgt   = (tgt == TGT_A) ? pre_a : pre_b;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        tgt_nxt     = tgt;
        act_nxt     = act;
        restart_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (pre_a | pre_b) begin
                    tgt_nxt = pre_a ? TGT_A : TGT_B;
                    act_nxt = fsm_a_on ? ACT_A : (fsm_b_on ? ACT_B : ACT_NONE);
                    cnt_nxt = '0;
                    if ((tgt_nxt == TGT_A && act_nxt == ACT_A && fsm_Ga) ||
                        (tgt_nxt == TGT_B && act_nxt == ACT_B && fsm_Gb))
                        state_nxt = GRANT;
                    else if (act_nxt == ACT_NONE)
                        state_nxt = CLR_IN;
                    else
                        state_nxt = EXIT_Y;
                end
            end
            EXIT_Y: begin
                if (tick) begin
                    if (cnt == Y_LAST) begin
                        state_nxt = CLR_IN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            CLR_IN: begin
                if (tick) begin
                    if (cnt == C_LAST) begin
                        state_nxt = GRANT;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            GRANT: begin
                // Counter parks at H_LAST while the request is still held
                if (tick) begin
                    if (cnt == H_LAST) begin
                        if (!pre_tgt) begin
                            state_nxt = CLR_OUT;
                            cnt_nxt   = '0;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            CLR_OUT: begin
                if (tick) begin
                    if (cnt == C_LAST) begin
                        state_nxt   = IDLE;
                        cnt_nxt     = '0;
                        restart_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // A conflicting FSM pattern is never passed through; it is forced to all red
        lamps_nxt = ALL_RED;
        case (state_nxt)
            IDLE:    lamps_nxt = (fsm_a_on && fsm_b_on) ? ALL_RED : fsm_lamps;
            EXIT_Y:  lamps_nxt = (act_nxt == ACT_A) ? YEL_A :
                                 (act_nxt == ACT_B) ? YEL_B : ALL_RED;
            GRANT:   lamps_nxt = (tgt_nxt == TGT_A) ? GRN_A : GRN_B;
            default: lamps_nxt = ALL_RED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            tgt            <= TGT_A;
            act            <= ACT_NONE;
            lamps          <= ALL_RED;
            preempt_active <= 1'b0;
            fsm_restart    <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            tgt            <= tgt_nxt;
            act            <= act_nxt;
            lamps          <= lamps_nxt;
            preempt_active <= (state_nxt != IDLE);
            fsm_restart    <= restart_nxt;
        end
    end

    assign {Ga, Ya, Ra, Gb, Yb, Rb} = lamps;

endmodule

// File: tb/tb_tlc_preempt_ctrl.sv
// Scoreboard bench for tlc_preempt_ctrl: a phase-schedule model pushes expected outputs per edge,
// a negedge monitor pops and compares them and checks the no-conflict invariant.
module tb_tlc_preempt_ctrl;
    localparam int YT = 3, CT = 2, HT = 4;

    localparam logic [5:0] RED2 = 6'b001_001;
    localparam logic [5:0] YA   = 6'b010_001;
    localparam logic [5:0] YB   = 6'b001_010;
    localparam logic [5:0] GA   = 6'b100_001;
    localparam logic [5:0] GB   = 6'b001_100;

    logic clk = 1'b0;
    logic reset, tick, pre_a, pre_b;
    logic fsm_Ga, fsm_Ya, fsm_Ra, fsm_Gb, fsm_Yb, fsm_Rb;
    logic Ga, Ya, Ra, Gb, Yb, Rb, preempt_active, fsm_restart;

    tlc_preempt_ctrl #(.n(3), .YELLOW_T(YT), .CLEAR_T(CT), .HOLD_T(HT)) dut (
        .clk(clk), .reset(reset), .tick(tick), .pre_a(pre_a), .pre_b(pre_b),
        .fsm_Ga(fsm_Ga), .fsm_Ya(fsm_Ya), .fsm_Ra(fsm_Ra),
        .fsm_Gb(fsm_Gb), .fsm_Yb(fsm_Yb), .fsm_Rb(fsm_Rb),
        .Ga(Ga), .Ya(Ya), .Ra(Ra), .Gb(Gb), .Yb(Yb), .Rb(Rb),
        .preempt_active(preempt_active), .fsm_restart(fsm_restart)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] lamps;
        logic       active;
        logic       restart;
    } exp_t;

    typedef struct {
        logic [5:0] lamps;
        int         ticks;
        bit         hold;
    } phase_t;

    exp_t   sb[$];
    phase_t ph[$];
    int     left;
    bit     tgt_b;
    int     vectors = 0;
    int     miscompares = 0;

    function automatic phase_t mk(logic [5:0] l, int t, bit h);
        phase_t p;
        p.lamps = l; p.ticks = t; p.hold = h;
        return p;
    endfunction

    function automatic logic [5:0] pass_lamps(logic [5:0] f);
        return ((f[5] | f[4]) && (f[2] | f[1])) ? RED2 : f;
    endfunction

    // Model: a preemption is a queue of timed phases; the grant phase may be extended by the request
    always @(posedge clk) begin
        exp_t       e;
        logic [5:0] f;
        bit         a_on, b_on, act_b, pre_t;
        f = {fsm_Ga, fsm_Ya, fsm_Ra, fsm_Gb, fsm_Yb, fsm_Rb};
        e.restart = 1'b0;
        if (reset) begin
            ph.delete();
            e.lamps = RED2;
        end else if (ph.size() == 0) begin
            if (pre_a | pre_b) begin
                tgt_b = !pre_a;
                a_on  = fsm_Ga | fsm_Ya;
                b_on  = fsm_Gb | fsm_Yb;
                act_b = !a_on;
                if (a_on || b_on) begin
                    if (!(act_b == tgt_b && (tgt_b ? fsm_Gb : fsm_Ga)))
                        ph.push_back(mk(act_b ? YB : YA, YT, 1'b0));
                    else
                        ; // already green on the requested side
                end
                if (!(a_on || b_on) || !(act_b == tgt_b && (tgt_b ? fsm_Gb : fsm_Ga)))
                    ph.push_back(mk(RED2, CT, 1'b0));
                ph.push_back(mk(tgt_b ? GB : GA, HT, 1'b1));
                ph.push_back(mk(RED2, CT, 1'b0));
                left    = ph[0].ticks;
                e.lamps = ph[0].lamps;
            end else begin
                e.lamps = pass_lamps(f);
            end
        end else begin
            pre_t = tgt_b ? pre_b : pre_a;
            if (tick) begin
                if (left > 1) left--;
                else if (!(ph[0].hold && pre_t)) begin
                    void'(ph.pop_front());
                    if (ph.size() == 0) e.restart = 1'b1;
                    else left = ph[0].ticks;
                end
            end
            e.lamps = (ph.size() != 0) ? ph[0].lamps : pass_lamps(f);
        end
        e.active = (ph.size() != 0);
        sb.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        if (sb.size() != 0) begin
            e   = sb.pop_front();
            got = {Ga, Ya, Ra, Gb, Yb, Rb, preempt_active, fsm_restart};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL outputs t=%0t got GYR_a/GYR_b/act/rst=%b required %b", $time, got, e);
            end
            vectors++;
            if ((Ga | Ya) & (Gb | Yb)) begin
                miscompares++;
                $display("FAIL safety t=%0t got lamps=%b required no dual green/yellow", $time, got[7:2]);
            end
        end
    end

    int tcnt = 0;
    task automatic cyc(int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            tick = (tcnt == 3);
            tcnt = (tcnt + 1) % 4;
        end
    endtask

    task automatic set_fsm(logic [5:0] l);
        {fsm_Ga, fsm_Ya, fsm_Ra, fsm_Gb, fsm_Yb, fsm_Rb} = l;
    endtask

    initial begin
        logic [5:0] legal [5];
        legal[0] = GA; legal[1] = YA; legal[2] = GB; legal[3] = YB; legal[4] = RED2;
        reset = 1'b1; tick = 1'b0; pre_a = 1'b0; pre_b = 1'b0;
        set_fsm(6'b000_000);

        // reset then pass-through
        cyc(2);
        set_fsm(GA);
        reset = 1'b0;
        cyc(4);
        // cross-direction preempt from a 1-clk pulse
        pre_b = 1'b1; cyc(1); pre_b = 1'b0;
        cyc(4 * (YT + CT + HT + CT) + 8);
        // same-direction preempt, request held 10 ticks
        pre_a = 1'b1; cyc(40); pre_a = 1'b0;
        cyc(30);
        // simultaneous requests while B green, then B served afterwards
        set_fsm(GB);
        pre_a = 1'b1; pre_b = 1'b1; cyc(1); pre_a = 1'b0;
        cyc(80); pre_b = 1'b0;
        cyc(30);
        // reset during grant
        set_fsm(GA);
        pre_b = 1'b1; cyc(4 * (YT + CT + 1) + 2);
        reset = 1'b1; cyc(1); reset = 1'b0; pre_b = 1'b0;
        cyc(10);
        // long hold: saturation with a narrow counter
        pre_a = 1'b1; cyc(200); pre_a = 1'b0;
        cyc(40);
        // randomized lamps and requests
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(63) == 0) pre_a = ~pre_a;
            if ($urandom_range(63) == 0) pre_b = ~pre_b;
            if ($urandom_range(7) == 0) begin
                if ($urandom_range(19) == 0) set_fsm(6'($urandom));
                else set_fsm(legal[$urandom_range(4)]);
            end
            if ($urandom_range(2999) == 0) reset = 1'b1;
            else reset = 1'b0;
            cyc(1);
        end
        reset = 1'b0;
        cyc(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
